// File: rtl/seq_multiplier_if.sv
// Handshake and operand bundle for the sequential multiplier.
// The master side issues requests. The slave side (the multiplier) returns status and the product.
interface seq_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     op1;
  logic [WIDTH-1:0]     op2;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   res;

  modport master (
    output start, signed_mode, op1, op2,
    input  busy, done, res
  );

  modport slave (
    input  start, signed_mode, op1, op2,
    output busy, done, res
  );
endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add sequential multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Signed operands are reduced to magnitudes on accept.
// The sign is reapplied once, on the final iteration.
// One result is produced every WIDTH+1 clocks when requests are issued back to back.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  seq_multiplier_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int ACC_W = 2 * WIDTH + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Unsigned magnitude of an operand; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sm);
    magnitude = (sm && v[WIDTH-1]) ? ((~v) + WIDTH'(1)) : v;
  endfunction

  // Reapply the product sign. A zero magnitude negates to zero, so there is no negative zero.
  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                    input logic               neg);
    apply_sign = neg ? ((~p) + (2*WIDTH)'(1)) : p;
  endfunction

  state_t               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;

  logic [WIDTH:0]       upper_sum;
  logic [ACC_W-1:0]     acc_step;

  // One shift-add step: conditionally add the multiplicand into the upper half, then shift right.
  // The upper half stays below 2^WIDTH after each shift, so the W+1-bit sum cannot overflow.
  always_comb begin
    upper_sum = acc_q[2*WIDTH:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_step  = {upper_sum, acc_q[WIDTH-1:0]} >> 1;
  end

  // Next-state logic: accept in IDLE, iterate in RUN, publish the result on the last step.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    res_d    = res_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = magnitude(bus.op1, bus.signed_mode);
          mplier_d = magnitude(bus.op2, bus.signed_mode);
          neg_d    = bus.signed_mode & (bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = CNT_W'(WIDTH);
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          res_d   = apply_sign(acc_step[2*WIDTH-1:0], neg_q);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; an asynchronous reset aborts any operation in flight without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_q    <= res_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH=8 and WIDTH=16.
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(8))  b8  ();
  seq_multiplier_if #(.WIDTH(16)) b16 ();

  seq_multiplier #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));
  seq_multiplier #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Mathematical product, truncated to 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input bit sm,
                                          input logic [31:0] a, input logic [31:0] b);
    longint m, sa, sb, p, m2;
    m  = (longint'(1) << w) - 1;
    m2 = (longint'(1) << (2 * w)) - 1;
    sa = longint'(a) & m;
    sb = longint'(b) & m;
    if (sm) begin
      if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
      if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
    end
    p = sa * sb;
    return 64'(p & m2);
  endfunction

  task automatic drive(input int w, input bit s, input bit sm,
                       input logic [31:0] a, input logic [31:0] b);
    if (w == 8) begin
      b8.start = s; b8.signed_mode = sm; b8.op1 = a[7:0]; b8.op2 = b[7:0];
    end else begin
      b16.start = s; b16.signed_mode = sm; b16.op1 = a[15:0]; b16.op2 = b[15:0];
    end
  endtask

  function automatic logic get_done(input int w);
    return (w == 8) ? b8.done : b16.done;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 8) ? b8.busy : b16.busy;
  endfunction

  function automatic logic [63:0] get_res(input int w);
    return (w == 8) ? 64'(b8.res) : 64'(b16.res);
  endfunction

  // Issue one request and check the busy length, the latency, the done width and the result.
  task automatic run_op(input int w, input bit sm, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag);
    int cyc = 0;
    int busy_cnt = 0;
    bit got = 0;
    @(negedge clk);
    drive(w, 1'b1, sm, a, b);
    @(negedge clk);
    drive(w, 1'b0, ~sm, ~a, ~b);
    while (cyc < w + 6) begin
      if (get_done(w)) begin
        got = 1;
        break;
      end
      if (get_busy(w)) busy_cnt++;
      cyc++;
      @(negedge clk);
    end
    chk_val({tag, " done seen"}, 64'(got), 64'd1);
    chk_val({tag, " latency"}, 64'(cyc), 64'(w));
    chk_val({tag, " busy cycles"}, 64'(busy_cnt), 64'(w));
    chk_val({tag, " res"}, get_res(w), exp);
    chk_val({tag, " busy at done"}, 64'(get_busy(w)), 64'd0);
    @(negedge clk);
    chk_val({tag, " done one cycle"}, 64'(get_done(w)), 64'd0);
    chk_val({tag, " res held"}, get_res(w), exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx, ndone, done_idx;
    logic [63:0] done_res;
    logic [31:0] a, b;
    bit sm;

    drive(8, 1'b0, 1'b0, 0, 0);
    drive(16, 1'b0, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    chk_val("reset busy8", 64'(b8.busy), 64'd0);
    chk_val("reset done8", 64'(b8.done), 64'd0);
    chk_val("reset res8", 64'(b8.res), 64'd0);
    chk_val("reset res16", 64'(b16.res), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk_val("idle busy8", 64'(b8.busy), 64'd0);

    // Directed WIDTH=8 cases.
    run_op(8, 1'b0, 'hFF, 'hFF, 64'hFE01, "u8 ff*ff");
    run_op(8, 1'b1, 'hFF, 'hFF, 64'h0001, "s8 -1*-1");
    run_op(8, 1'b1, 'h80, 'h7F, 64'hC080, "s8 -128*127");
    run_op(8, 1'b1, 'h80, 'h80, 64'h4000, "s8 -128*-128");
    run_op(8, 1'b1, 'h00, 'h80, 64'h0000, "s8 0*-128");
    run_op(8, 1'b1, 'hFE, 'h03, 64'hFFFA, "s8 -2*3");

    // Back-to-back: the second request arrives in the done cycle, and a pulse mid-RUN is ignored.
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 3, 5);
    @(negedge clk);
    drive(8, 1'b0, 1'b0, 0, 0);
    idx = 0;
    while (!b8.done && idx < 20) begin
      @(negedge clk);
      idx++;
    end
    chk_val("b2b first done", 64'(b8.done), 64'd1);
    chk_val("b2b first res", 64'(b8.res), 64'h000F);
    drive(8, 1'b1, 1'b0, 'h0C, 'h0A);
    @(negedge clk);
    drive(8, 1'b0, 1'b0, 0, 0);
    idx = 1;
    ndone = 0;
    done_idx = 0;
    done_res = '0;
    while (idx <= 30) begin
      if (b8.done) begin
        ndone++;
        if (ndone == 1) begin
          done_idx = idx;
          done_res = 64'(b8.res);
        end
      end
      if (idx == 3) drive(8, 1'b1, 1'b0, 'h11, 'h11);
      if (idx == 4) drive(8, 1'b0, 1'b0, 0, 0);
      @(negedge clk);
      idx++;
    end
    chk_val("b2b done count", 64'(ndone), 64'd1);
    chk_val("b2b spacing", 64'(done_idx), 64'd9);
    chk_val("b2b second res", done_res, 64'h0078);
    chk_val("b2b res after", 64'(b8.res), 64'h0078);

    // Reset in the middle of an operation.
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 'hAA, 'h55);
    @(negedge clk);
    drive(8, 1'b0, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk_val("abort busy", 64'(b8.busy), 64'd0);
    chk_val("abort done", 64'(b8.done), 64'd0);
    chk_val("abort res", 64'(b8.res), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (b8.done) ndone++;
    end
    chk_val("abort no done", 64'(ndone), 64'd0);
    run_op(8, 1'b0, 'h02, 'h03, 64'h0006, "u8 after reset");

    // Directed WIDTH=16 cases.
    run_op(16, 1'b0, 'hFFFF, 'hFFFF, 64'hFFFE0001, "u16 ffff*ffff");
    run_op(16, 1'b1, 'h8000, 'hFFFF, 64'h00008000, "s16 min*-1");

    // Random operands in both modes against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      sm = 1'($urandom_range(0, 1));
      a  = $urandom & 32'hFF;
      b  = $urandom & 32'hFF;
      run_op(8, sm, a, b, ref_mul(8, sm, a, b), "rand8");
    end
    for (int i = 0; i < 40; i++) begin
      sm = 1'($urandom_range(0, 1));
      a  = $urandom & 32'hFFFF;
      b  = $urandom & 32'hFFFF;
      run_op(16, sm, a, b, ref_mul(16, sm, a, b), "rand16");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
